// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control path: opcodes, FSM states,
// ALU operation and PC source selects.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that holds the FSM in MEM for MEM_LAT cycles; last flags the
// final cycle (count == 0).
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int CW = ($clog2(MEM_LAT + 1) < 1) ? 1 : $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(MEM_LAT - 1);
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences each accepted instruction through
// DECODE/EXEC/MEM/WB and drives datapath strobes, mux selects and PC update.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               done,
    output logic               illegal,
    output logic [2:0]         state_dbg
);
    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       ready_c, cnt_load, cnt_dec, cnt_last;
    logic [1:0] aop_c;

    mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ready_c   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    op_d    = opcode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_legal(op_q)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW: begin
                        cnt_load = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = zero ? PC_BR : PC_SEQ;
                        done     = 1'b1;
                        state_d  = S_IDLE;
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        done     = 1'b1;
                        state_d  = S_IDLE;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                cnt_dec   = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (cnt_last) begin
                    if (op_q == OP_SW) begin
                        done     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Static selects stay stable from DECODE to the final state; zero in IDLE.
    always_comb begin
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        aop_c      = ALU_ADD;
        if (state_q != S_IDLE) begin
            case (op_q)
                OP_R:    begin reg_dst = 1'b1; aop_c = ALU_FUNCT; end
                OP_LW:   begin mem_to_reg = 1'b1; alu_src = 1'b1; end
                OP_SW:   alu_src = 1'b1;
                OP_ADDI: alu_src = 1'b1;
                OP_BEQ:  aop_c = ALU_SUB;
                default: ;
            endcase
        end
    end

    assign alu_op      = ALUOP_W'(aop_c);
    assign instr_ready = ready_c & ~rst;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with MEM_LAT = 3; expected values
// are hand-computed from the cycle-by-cycle state sequence.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [5:0] opcode;
    logic       zero;
    logic       reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       done, illegal;
    logic [2:0] state_dbg;

    int passed = 0;
    int total  = 0;

    multicycle_control_fsm #(.MEM_LAT(3), .ALUOP_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .zero        (zero),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .done        (done),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present opcode for one transfer edge; returns in cycle 1 (DECODE).
    task automatic issue(input logic [5:0] op);
        instr_valid = 1'b1;
        opcode      = op;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; zero = 1'b0;
        #1;
        chk("rst_ready", {7'd0, instr_ready}, 8'd0);
        chk("rst_state", {5'd0, state_dbg}, 8'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("idle_ready", {7'd0, instr_ready}, 8'd1);
        chk("idle_done", {7'd0, done}, 8'd0);

        // R-type: DECODE, EXEC, WB
        issue(6'd0);
        chk("r_c1_state", {5'd0, state_dbg}, 8'd1);
        chk("r_c1_ready", {7'd0, instr_ready}, 8'd0);
        step();
        chk("r_c2_state", {5'd0, state_dbg}, 8'd2);
        chk("r_c2_done", {7'd0, done}, 8'd0);
        step();
        chk("r_c3_state", {5'd0, state_dbg}, 8'd4);
        chk("r_c3_ctl", {2'd0, reg_write, reg_dst, alu_op, done, pc_write}, 8'b00_1_1_10_1_1);
        chk("r_c3_pcsrc", {6'd0, pc_src}, 8'd0);
        step();
        chk("r_c4_state", {5'd0, state_dbg}, 8'd0);
        chk("r_c4_done", {7'd0, done}, 8'd0);

        // LW: MEM for 3 cycles, then WB at cycle 6
        issue(6'd35);
        step();
        chk("lw_c2_mrd", {7'd0, mem_read}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lw_mem%0d", i), {4'd0, state_dbg, mem_read}, {4'd0, 3'd3, 1'b1});
            chk($sformatf("lw_mem%0d_done", i), {6'd0, done, reg_write}, 8'd0);
        end
        step();
        chk("lw_wb", {2'd0, mem_read, mem_to_reg, reg_write, done, pc_write, alu_src}, 8'b00_0_1_1_1_1_1);
        step();
        chk("lw_idle", {5'd0, state_dbg}, 8'd0);

        // SW: mem_write 3 cycles, done in the last MEM cycle (cycle 5)
        issue(6'd43);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sw_mem%0d", i), {5'd0, mem_write, mem_read, reg_write}, 8'b100);
            chk($sformatf("sw_mem%0d_done", i), {6'd0, done, pc_write}, (i == 2) ? 8'b11 : 8'b00);
        end
        step();
        chk("sw_idle", {4'd0, state_dbg, reg_write}, 8'd0);

        // BEQ taken / not taken
        issue(6'd4);
        zero = 1'b1;
        step();
        chk("beq_t", {1'b0, pc_write, pc_src, done, alu_op, reg_write}, 8'b0_1_01_1_01_0);
        step();
        chk("beq_t_idle", {5'd0, state_dbg}, 8'd0);
        issue(6'd4);
        zero = 1'b0;
        step();
        chk("beq_nt", {3'd0, pc_write, pc_src, done}, 8'b000_1_00_1);
        step();

        // J
        issue(6'd2);
        step();
        chk("j", {3'd0, pc_write, pc_src, done}, 8'b000_1_10_1);
        step();

        // Illegal opcode
        issue(6'd63);
        chk("ill_c1", {5'd0, illegal, done, pc_write}, 8'b100);
        step();
        chk("ill_c2", {4'd0, state_dbg, illegal}, 8'd0);
        chk("ill_c2_ready", {7'd0, instr_ready}, 8'd1);

        // Reset in the second MEM cycle of SW
        issue(6'd43);
        step(); step(); step();
        chk("rst_sw_pre", {4'd0, state_dbg, mem_write}, {4'd0, 3'd3, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_sw_mw", {5'd0, mem_write, done, pc_write}, 8'd0);
        chk("rst_sw_state", {5'd0, state_dbg}, 8'd0);
        step();
        rst = 1'b0;
        issue(6'd0);
        step(); step();
        chk("post_rst_r", {3'd0, state_dbg, done, reg_write}, {3'd0, 3'd4, 2'b11});
        step();

        // Back-to-back: BEQ with valid held, opcode changes to ADDI mid-flight
        instr_valid = 1'b1;
        opcode      = 6'd4;
        zero        = 1'b0;
        step();
        opcode = 6'd8;
        chk("b2b_c1", {4'd0, state_dbg, instr_ready}, {4'd0, 3'd1, 1'b0});
        step();
        chk("b2b_beq", {3'd0, done, alu_op, pc_src}, 8'b000_1_01_00);
        step();
        chk("b2b_idle", {4'd0, state_dbg, instr_ready}, {4'd0, 3'd0, 1'b1});
        step();
        instr_valid = 1'b0;
        chk("b2b_addi_c1", {2'd0, state_dbg, alu_src, reg_dst, 1'b0}, {2'd0, 3'd1, 1'b1, 1'b0, 1'b0});
        chk("b2b_addi_aop", {6'd0, alu_op}, 8'd0);
        step(); step();
        chk("b2b_addi_wb", {3'd0, state_dbg, reg_write, done}, {3'd0, 3'd4, 2'b11});
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle successor to the single-cycle control path. It sequences each accepted instruction through DECODE / EXEC / MEM / WB states and drives all datapath strobes and mux selects, including PC update. Data-memory latency is parametrised. Branch, jump and ADDI opcodes are supported, and illegal opcodes are flagged. The block sits between the instruction source (valid/ready handshake) and the mipscpu datapath.

Parameters:
MEM_LAT, 1, number of MEM-state cycles for LW/SW (legal range 1..15; mem_read or mem_write held for all of them)
ALUOP_W, 2, width of alu_op output

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  new instruction word available
instr_ready  out  1  FSM can accept; transfer when instr_valid & instr_ready
opcode  in  6  instr[31:26], sampled only on transfer
zero  in  1  ALU zero flag, sampled in EXEC for BEQ
reg_write  out  1  register-file write strobe
mem_read  out  1  data-memory read strobe
mem_write  out  1  data-memory write strobe
mem_to_reg  out  1  WB mux: 1 = memory data
reg_dst  out  1  1 = rd, 0 = rt
alu_src  out  1  1 = sign-extended immediate
alu_op  out  ALUOP_W  0 = add, 1 = sub (BEQ), 2 = funct-decoded
pc_write  out  1  PC load enable
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
done  out  1  one-cycle pulse in the final cycle of an instruction
illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
state_dbg  out  3  current state encoding

Behaviour:
- Opcodes: R = 0, J = 2, BEQ = 4, ADDI = 8, LW = 35, SW = 43. Any other value is illegal.
- States: IDLE = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Encodings 5..7 are unreachable and recover to IDLE.
- IDLE:
  - instr_ready = 1 (forced 0 while rst is high).
  - On transfer: latch opcode into op_q and go to DECODE.
- DECODE:
  - Illegal op_q: illegal = 1, go to IDLE. No done, no pc_write.
  - Otherwise go to EXEC.
- EXEC:
  - R or ADDI: go to WB.
  - LW or SW: load wait counter with MEM_LAT-1, go to MEM.
  - BEQ: pc_write = 1, pc_src = zero ? 1 : 0, done = 1, go to IDLE.
  - J: pc_write = 1, pc_src = 2, done = 1, go to IDLE.
- MEM:
  - mem_read = 1 (LW) or mem_write = 1 (SW) in every MEM cycle.
  - Counter decrements each cycle. The state is left when the count is 0.
  - LW then goes to WB.
  - SW then goes to IDLE with done = 1, pc_write = 1, pc_src = 0 in that last MEM cycle.
- WB:
  - reg_write = 1, done = 1, pc_write = 1, pc_src = 0 for exactly one cycle, then go to IDLE.
- Static controls (mem_to_reg, reg_dst, alu_src, alu_op):
  - Decoded from op_q in DECODE through the final state. All are 0 in IDLE.
  - R: 0 / 1 / 0 / 2.
  - LW: 1 / 0 / 1 / 0.
  - SW: 0 / 0 / 1 / 0.
  - ADDI: 0 / 0 / 1 / 0.
  - BEQ: 0 / 0 / 0 / 1.
  - J: all 0.
- Outputs are combinational from state, op_q, counter and zero (zero only in EXEC). There are no other input-to-output paths.
- Latency, in cycles after the transfer edge, to done:
  - R / ADDI: 3.
  - LW: 3 + MEM_LAT.
  - SW: 2 + MEM_LAT.
  - BEQ / J: 2.
  - Illegal: 1 (illegal pulse instead of done).
  - Next transfer is possible in the cycle after done or illegal.
- instr_valid outside IDLE is ignored. No queuing, and opcode is not sampled.
- Reset, asynchronous at any time including mid-instruction:
  - state = IDLE, op_q = 0, counter = 0.
  - All strobes, done, illegal and pc_write drop to 0 immediately. No partial reg_write or mem_write may be emitted.
- Back-to-back: instr_valid held high with a new opcode is accepted on the first IDLE cycle after done.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - opcode constants OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW.
  - state encodings.
  - alu_op and pc_src constants.
- One natural sub-module: mem_wait_counter.
  - Parameter MEM_LAT; inputs load and dec.
  - Output last (count == 0).
  - Width $clog2(MEM_LAT+1), minimum 1.

Test Plan:
- Reset then R (op 0): instr_ready = 1 in IDLE.
  - Cycles 1..3: states 1, 2, 4.
  - Cycle 3: reg_write = 1, reg_dst = 1, alu_op = 2, done = 1, pc_write = 1, pc_src = 0.
- LW (op 35) with MEM_LAT = 3:
  - mem_read high for exactly 3 cycles.
  - Then one WB cycle with mem_to_reg = 1, reg_write = 1; done at cycle 6.
  - SW (op 43): mem_write high 3 cycles, done at cycle 5, reg_write never high.
- BEQ (op 4), zero = 1: cycle 2 pc_write = 1, pc_src = 1, done = 1. Repeat with zero = 0: pc_src = 0.
- J (op 2): pc_src = 2 at cycle 2. Illegal op 63: illegal = 1 at cycle 1, no done, back in IDLE at cycle 2.
- Assert rst in the second MEM cycle of SW (MEM_LAT = 3):
  - mem_write falls in the same timestep; state_dbg = 0.
  - After release, the next R instruction completes normally.
- Hold instr_valid high during a BEQ with opcode changing to 8: the change is ignored. The ADDI is accepted the cycle after done (alu_src = 1, reg_dst = 0).
